// File: rtl/processor_exe_wb.sv
// Execute/writeback stage of the 16-bit RSA ASIP: single-cycle SET/ADD/CMPEQ
// and a fixed-latency bit-serial modular exponentiation engine.
module processor_exe_wb #(
  parameter int ARQ      = 16,
  parameter int REG_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  logic [1:0]          alu_op,
  input  logic                mux_exe,
  input  logic [ARQ-1:0]      src1,
  input  logic [ARQ-1:0]      src2,
  input  logic [ARQ-1:0]      src3,
  input  logic [ARQ-1:0]      imm,
  input  logic [REG_BITS-1:0] rd_in,
  output logic [ARQ-1:0]      wb_result,
  output logic [REG_BITS-1:0] wb_rd,
  output logic                wr_reg_en,
  output logic                flag_eq,
  output logic                flag_c,
  output logic                mod_err,
  output logic                busy
);

  // state | meaning
  // IDLE  | accepting bundles, single-cycle ops complete here
  // INIT  | base_r = base mod m
  // MUL   | t = res_r*base_r mod m, committed when current exponent bit is 1
  // SQR   | base_r = base_r^2 mod m; after the last bit, write back and go IDLE
  typedef enum logic [1:0] {IDLE, INIT, MUL, SQR} state_t;

  localparam int CW = $clog2(ARQ);
  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_MODEX = 2'b01;
  localparam logic [1:0] OP_CMPEQ = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  state_t state, next_state;

  logic [ARQ-1:0] mod_r, exp_r, base_r, res_r, op_a, op_b;
  logic [ARQ:0]   acc;
  logic [CW-1:0]  bit_cnt, ebit_cnt;

  logic [ARQ-1:0] opnd_b;
  logic           accept, last_step, last_bit;
  logic [ARQ:0]   m_ext, dbl, dbl_r, add, add_r, step;

  assign opnd_b    = mux_exe ? imm : src2;
  assign busy      = (state != IDLE);
  assign accept    = valid_in && !busy;
  assign last_step = (bit_cnt == '0);
  assign last_bit  = (ebit_cnt == '0);

  // One interleaved modmul step; acc < m is kept so a single subtract suffices
  always_comb begin
    m_ext = {1'b0, mod_r};
    dbl   = acc << 1;
    dbl_r = (dbl >= m_ext) ? dbl - m_ext : dbl;
    add   = dbl_r + {1'b0, op_a};
    add_r = (add >= m_ext) ? add - m_ext : add;
    step  = op_b[bit_cnt] ? add_r : dbl_r;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept && alu_op == OP_MODEX && src3 != '0) next_state = INIT;
      INIT: if (last_step) next_state = MUL;
      MUL:  if (last_step) next_state = SQR;
      SQR:  if (last_step) next_state = last_bit ? IDLE : MUL;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_result <= '0;
      wb_rd     <= '0;
      wr_reg_en <= 1'b0;
      flag_eq   <= 1'b0;
      flag_c    <= 1'b0;
      mod_err   <= 1'b0;
      mod_r     <= '0;
      exp_r     <= '0;
      base_r    <= '0;
      res_r     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      ebit_cnt  <= '0;
    end else begin
      wr_reg_en <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          wb_rd <= rd_in;
          case (alu_op)
            OP_SET: begin
              wb_result <= opnd_b;
              wr_reg_en <= 1'b1;
            end
            OP_ADD: begin
              {flag_c, wb_result} <= {1'b0, src1} + {1'b0, opnd_b};
              wr_reg_en <= 1'b1;
            end
            OP_CMPEQ: flag_eq <= (src1 == opnd_b);
            default: begin
              if (src3 == '0) begin
                mod_err   <= 1'b1;
                wb_result <= '0;
                wr_reg_en <= 1'b1;
              end else begin
                // base is walked bit-serially against a=1 so base >= m reduces fully
                mod_err  <= 1'b0;
                mod_r    <= src3;
                exp_r    <= src2;
                res_r    <= (src3 == ARQ'(1)) ? '0 : ARQ'(1);
                op_a     <= ARQ'(1);
                op_b     <= src1;
                acc      <= '0;
                bit_cnt  <= CW'(ARQ - 1);
                ebit_cnt <= CW'(ARQ - 1);
              end
            end
          endcase
        end
        INIT: begin
          if (last_step) begin
            base_r  <= step[ARQ-1:0];
            op_a    <= res_r;
            op_b    <= step[ARQ-1:0];
            acc     <= '0;
            bit_cnt <= CW'(ARQ - 1);
          end else begin
            acc     <= step;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        MUL: begin
          if (last_step) begin
            if (exp_r[0]) res_r <= step[ARQ-1:0];
            op_a    <= base_r;
            op_b    <= base_r;
            acc     <= '0;
            bit_cnt <= CW'(ARQ - 1);
          end else begin
            acc     <= step;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        SQR: begin
          if (last_step) begin
            base_r  <= step[ARQ-1:0];
            exp_r   <= exp_r >> 1;
            op_a    <= res_r;
            op_b    <= step[ARQ-1:0];
            acc     <= '0;
            bit_cnt <= CW'(ARQ - 1);
            if (last_bit) begin
              wb_result <= res_r;
              wr_reg_en <= 1'b1;
            end else begin
              ebit_cnt <= ebit_cnt - 1'b1;
            end
          end else begin
            acc     <= step;
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_exe_wb.sv
// Directed bench for processor_exe_wb: vector table for single-cycle ops,
// hand-written sequences for MODEX latency, stalls and reset abort.
module tb_processor_exe_wb;

  localparam int ARQ = 16;
  localparam int REG_BITS = 3;
  localparam int MODEX_CYCLES = ARQ + 2 * ARQ * ARQ;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                valid_in = 1'b0;
  logic [1:0]          alu_op = 2'b00;
  logic                mux_exe = 1'b0;
  logic [ARQ-1:0]      src1 = '0, src2 = '0, src3 = '0, imm = '0;
  logic [REG_BITS-1:0] rd_in = '0;
  logic [ARQ-1:0]      wb_result;
  logic [REG_BITS-1:0] wb_rd;
  logic                wr_reg_en, flag_eq, flag_c, mod_err, busy;

  int checks = 0;
  int errors = 0;

  processor_exe_wb #(.ARQ(ARQ), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_op(alu_op), .mux_exe(mux_exe),
    .src1(src1), .src2(src2), .src3(src3), .imm(imm), .rd_in(rd_in),
    .wb_result(wb_result), .wb_rd(wb_rd), .wr_reg_en(wr_reg_en),
    .flag_eq(flag_eq), .flag_c(flag_c), .mod_err(mod_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic        mux;
    logic [15:0] s1, s2, s3, im;
    logic [2:0]  rd;
    logic [15:0] e_res;
    logic [2:0]  e_rd;
    logic        e_we, e_eq, e_c, e_err, e_busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic mx,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                       input logic [15:0] i, input logic [2:0] r);
    valid_in = v; alu_op = op; mux_exe = mx;
    src1 = a; src2 = b; src3 = c; imm = i; rd_in = r;
  endtask

  task automatic check_all(input string tag, input logic [15:0] res, input logic [2:0] rd,
                           input logic we, input logic eq, input logic c,
                           input logic err, input logic bz);
    chk({tag, ".wb_result"}, 32'(wb_result), 32'(res));
    chk({tag, ".wb_rd"},     32'(wb_rd),     32'(rd));
    chk({tag, ".wr_reg_en"}, 32'(wr_reg_en), 32'(we));
    chk({tag, ".flag_eq"},   32'(flag_eq),   32'(eq));
    chk({tag, ".flag_c"},    32'(flag_c),    32'(c));
    chk({tag, ".mod_err"},   32'(mod_err),   32'(err));
    chk({tag, ".busy"},      32'(busy),      32'(bz));
  endtask

  // Issue a MODEX, poke valid_in during the stall, measure busy and the writeback.
  task automatic run_modex(input string tag, input logic [15:0] b, input logic [15:0] e,
                           input logic [15:0] m, input logic [2:0] r, input logic [15:0] exp_res,
                           input logic eq_hold, input logic c_hold);
    int cnt;
    int spurious;
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b1, b, e, m, 16'h0FFF, r);
    @(posedge clk); #1;
    chk({tag, ".busy_rise"}, 32'(busy), 32'd1);
    chk({tag, ".mod_err_clr"}, 32'(mod_err), 32'd0);
    cnt = 0;
    spurious = 0;
    while (busy && cnt < 2000) begin
      @(negedge clk);
      if (cnt % 3 == 1) drive(1'b1, 2'b00, 1'b1, 16'h1, 16'h2, 16'h3, 16'h0077, 3'd7);
      else              drive(1'b0, 2'b01, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
      @(posedge clk); #1;
      cnt++;
      if (busy && wr_reg_en) spurious++;
    end
    drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    chk({tag, ".busy_cycles"}, 32'(cnt), 32'(MODEX_CYCLES));
    chk({tag, ".early_we"}, 32'(spurious), 32'd0);
    check_all({tag, ".wb"}, exp_res, r, 1'b1, eq_hold, c_hold, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".we_pulse"}, 32'(wr_reg_en), 32'd0);
  endtask

  initial begin
    //          valid op     mux s1       s2       s3     imm      rd    e_res    e_rd  we  eq  c   err busy
    vecs[0] = '{1'b1, 2'b00, 1, 16'd0,    16'd0,   16'd0, 16'd20,  3'd0, 16'd20,  3'd0, 1, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 2'b00, 1, 16'd0,    16'd0,   16'd0, 16'd99,  3'd6, 16'd20,  3'd0, 0, 0, 0, 0, 0};
    vecs[2] = '{1'b1, 2'b11, 1, 16'd45,   16'd7,   16'd0, 16'd15,  3'd1, 16'd60,  3'd1, 1, 0, 0, 0, 0};
    vecs[3] = '{1'b1, 2'b11, 1, 16'hFFFF, 16'd7,   16'd0, 16'd1,   3'd3, 16'd0,   3'd3, 1, 0, 1, 0, 0};
    vecs[4] = '{1'b1, 2'b10, 0, 16'd20,   16'd28,  16'd0, 16'd20,  3'd4, 16'd0,   3'd4, 0, 0, 1, 0, 0};
    vecs[5] = '{1'b1, 2'b10, 0, 16'd28,   16'd28,  16'd0, 16'd5,   3'd5, 16'd0,   3'd5, 0, 1, 1, 0, 0};
    vecs[6] = '{1'b1, 2'b11, 0, 16'd1,    16'd2,   16'd0, 16'd500, 3'd6, 16'd3,   3'd6, 1, 1, 0, 0, 0};
    vecs[7] = '{1'b1, 2'b00, 0, 16'd0,    16'hABCD,16'd0, 16'd5,   3'd7, 16'hABCD,3'd7, 1, 1, 0, 0, 0};
    vecs[8] = '{1'b1, 2'b01, 1, 16'd5,    16'd3,   16'd0, 16'd1,   3'd2, 16'd0,   3'd2, 1, 1, 0, 1, 0};
    vecs[9] = '{1'b1, 2'b00, 1, 16'd3,    16'd4,   16'd5, 16'd9,   3'd1, 16'd9,   3'd1, 1, 1, 0, 1, 0};

    #12;
    check_all("reset", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].op, vecs[i].mux, vecs[i].s1, vecs[i].s2,
            vecs[i].s3, vecs[i].im, vecs[i].rd);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_res, vecs[i].e_rd, vecs[i].e_we,
                vecs[i].e_eq, vecs[i].e_c, vecs[i].e_err, vecs[i].e_busy);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(posedge clk); #1;
    chk("set_after_err.we_pulse", 32'(wr_reg_en), 32'd0);

    run_modex("mx20_28_45", 16'd20,  16'd28, 16'd45, 3'd2, 16'd25, 1'b1, 1'b0);
    run_modex("mx7_0_10",   16'd7,   16'd0,  16'd10, 3'd3, 16'd1,  1'b1, 1'b0);
    run_modex("mx50_3_1",   16'd50,  16'd3,  16'd1,  3'd4, 16'd0,  1'b1, 1'b0);
    run_modex("mx100_2_7",  16'd100, 16'd2,  16'd7,  3'd5, 16'd4,  1'b1, 1'b0);

    // Reset in the middle of a MODEX: outputs clear at once, no writeback later.
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b0, 16'd20, 16'd28, 16'd45, 16'd0, 3'd6);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    chk("abort.busy_rise", 32'(busy), 32'd1);
    repeat (100) @(posedge clk);
    #3 rst = 1'b0;
    #1 check_all("abort.reset", 16'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    begin
      int late_we = 0;
      int late_busy = 0;
      repeat (600) begin
        @(posedge clk); #1;
        if (wr_reg_en) late_we++;
        if (busy) late_busy++;
      end
      chk("abort.no_wb", 32'(late_we), 32'd0);
      chk("abort.no_busy", 32'(late_busy), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 2'b00, 1'b1, 16'd0, 16'd0, 16'd0, 16'd20, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    check_all("post_reset_set", 16'd20, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
